cube_edge_sequencer: RTL and testbench

- Initiator side of the line-drawer start/done interface.
- Latches 8 projected cube vertices on a frame request, then walks the fixed 12-edge cube topology.
- Per edge: presents endpoints to the line drawer, raises start, waits for done, releases start, moves to the next edge.
- Sits between the 3-D projection stage and the line rasteriser in the wireframe render path.

---
 rtl/cube_edge_sequencer_pkg.sv | 29 ++
 rtl/cube_edge_sequencer_if.sv | 22 ++
 rtl/cube_edge_sequencer_vertex_mux.sv | 26 ++
 rtl/cube_edge_sequencer.sv | 155 +++++++++++++++
 tb/tb_cube_edge_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cube_edge_sequencer_pkg.sv
// Shared types and the fixed cube edge topology for the wireframe edge sequencer.
// Vertex index bits are {z,y,x}; each edge is the pair (EDGE_A[i], EDGE_B[i]).
package cube_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP,
    FINISH
  } seq_state_t;

  localparam int NUM_EDGES = 12;

  localparam logic [2:0] EDGE_A [NUM_EDGES] = '{
    3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd7, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3
  };
  localparam logic [2:0] EDGE_B [NUM_EDGES] = '{
    3'd1, 3'd3, 3'd2, 3'd0, 3'd5, 3'd7, 3'd6, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7
  };

  // Out-of-range edge numbers fall back to vertex 0 so the lookup is total.
  function automatic logic [2:0] edge_vertex(input logic [3:0] idx, input logic second);
    if (idx >= 4'(NUM_EDGES)) return 3'd0;
    return second ? EDGE_B[idx] : EDGE_A[idx];
  endfunction

endpackage

// File: rtl/cube_edge_sequencer_if.sv
// Start/done handshake plus edge endpoints between the edge sequencer and the line drawer.
interface cube_edge_sequencer_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          line_start;
  logic          line_done;
  logic [XW-1:0] line_x0;
  logic [YW-1:0] line_y0;
  logic [XW-1:0] line_x1;
  logic [YW-1:0] line_y1;

  modport master (
    output line_start, line_x0, line_y0, line_x1, line_y1,
    input  line_done
  );

  modport slave (
    input  line_start, line_x0, line_y0, line_x1, line_y1,
    output line_done
  );
endinterface

// File: rtl/cube_edge_sequencer_vertex_mux.sv
// Combinational pick of one edge's two endpoint coordinates from the latched vertex set.
module cube_vertex_mux
  import cube_seq_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic [8*XW-1:0] vx,
  input  logic [8*YW-1:0] vy,
  input  logic [3:0]      edge_idx,
  output logic [XW-1:0]   x0,
  output logic [YW-1:0]   y0,
  output logic [XW-1:0]   x1,
  output logic [YW-1:0]   y1
);
  logic [2:0] va;
  logic [2:0] vb;

  assign va = edge_vertex(edge_idx, 1'b0);
  assign vb = edge_vertex(edge_idx, 1'b1);

  assign x0 = vx[int'(va)*XW +: XW];
  assign y0 = vy[int'(va)*YW +: YW];
  assign x1 = vx[int'(vb)*XW +: XW];
  assign y1 = vy[int'(vb)*YW +: YW];
endmodule

// File: rtl/cube_edge_sequencer.sv
// Walks the 12 cube edges, handing each endpoint pair to the line drawer via start/done.
// Optional per-edge watchdog enabled by defining CUBE_SEQ_WATCHDOG_EN.
module cube_edge_sequencer
  import cube_seq_pkg::*;
#(
  parameter int XW        = 11,
  parameter int YW        = 10,
  parameter int WD_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [8*XW-1:0]       vx,
  input  logic [8*YW-1:0]       vy,
  cube_edge_sequencer_if.master line_if,
  output logic [3:0]            edge_idx,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  err_timeout
);
  localparam logic [3:0] LAST_EDGE = 4'(NUM_EDGES - 1);

  seq_state_t      state, state_nxt;
  logic [8*XW-1:0] vx_q;
  logic [8*YW-1:0] vy_q;
  logic [3:0]      edge_q;
  logic [XW-1:0]   mux_x0, mux_x1;
  logic [YW-1:0]   mux_y0, mux_y1;
  logic            latch, load, advance, wd_expire;
  logic            start_c, busy_c, done_c;

  if (WD_CYCLES < 2) begin : g_wd_range
    $error("cube_edge_sequencer: WD_CYCLES must be at least 2");
  end

  cube_vertex_mux #(.XW(XW), .YW(YW)) u_mux (
    .vx       (vx_q),
    .vy       (vy_q),
    .edge_idx (edge_q),
    .x0       (mux_x0),
    .y0       (mux_y0),
    .x1       (mux_x1),
    .y1       (mux_y1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // GAP insists on seeing done low so a level-style done cannot retrigger the next edge.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    start_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          latch     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy_c    = 1'b1;
        load      = 1'b1;
        state_nxt = START;
      end
      START: begin
        busy_c    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy_c  = 1'b1;
        start_c = 1'b1;
        if (line_if.line_done || wd_expire) state_nxt = GAP;
      end
      GAP: begin
        busy_c = 1'b1;
        if (!line_if.line_done) begin
          if (edge_q == LAST_EDGE) begin
            state_nxt = FINISH;
          end else begin
            advance   = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      FINISH: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign line_if.line_start = start_c;
  assign frame_busy         = busy_c;
  assign frame_done         = done_c;
  assign edge_idx           = edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vx_q            <= '0;
      vy_q            <= '0;
      edge_q          <= '0;
      line_if.line_x0 <= '0;
      line_if.line_y0 <= '0;
      line_if.line_x1 <= '0;
      line_if.line_y1 <= '0;
    end else begin
      if (latch) begin
        vx_q   <= vx;
        vy_q   <= vy;
        edge_q <= '0;
      end
      if (advance) edge_q <= edge_q + 4'd1;
      if (load) begin
        line_if.line_x0 <= mux_x0;
        line_if.line_y0 <= mux_y0;
        line_if.line_x1 <= mux_x1;
        line_if.line_y1 <= mux_y1;
      end
    end
  end

`ifdef CUBE_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES) + 1;

  logic [WDW-1:0] wd_cnt;
  logic           err_q;

  assign wd_expire   = (state == WAIT) && !line_if.line_done && (wd_cnt == WDW'(WD_CYCLES - 1));
  assign err_timeout = err_q;

  // Counter restarts each START so every edge gets a full WD_CYCLES of WAIT time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == START)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) err_q <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cube_edge_sequencer.sv
// Directed bench for cube_edge_sequencer with a pulse/level/silent line-drawer responder.
// Watchdog steps are compiled only when CUBE_SEQ_WATCHDOG_EN is defined.
module tb_cube_edge_sequencer;
  localparam int XW = 11;
  localparam int YW = 10;
`ifdef CUBE_SEQ_WATCHDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 4096;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_start;
  logic [8*XW-1:0] vx;
  logic [8*YW-1:0] vy;
  logic [3:0]     edge_idx;
  logic           frame_busy;
  logic           frame_done;
  logic           err_timeout;

  cube_edge_sequencer_if #(.XW(XW), .YW(YW)) lif ();

  cube_edge_sequencer #(.XW(XW), .YW(YW), .WD_CYCLES(WD)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .vx          (vx),
    .vy          (vy),
    .line_if     (lif),
    .edge_idx    (edge_idx),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_mode = 0;

  int   rise_cnt = 0;
  int   done_cnt = 0;
  int   low_cnt  = 0;
  logic prev_start = 1'b0;
  logic [XW-1:0] cap_x0 [12];
  logic [YW-1:0] cap_y0 [12];
  logic [XW-1:0] cap_x1 [12];
  logic [YW-1:0] cap_y1 [12];
  int   gap_at [12];

  int base_x [8] = '{10, 50, 10, 50, 30, 70, 30, 70};
  int base_y [8] = '{10, 10, 50, 50, 25, 25, 65, 65};
  int ex0 [12] = '{10, 50, 50, 10, 30, 70, 70, 30, 10, 50, 10, 50};
  int ey0 [12] = '{10, 10, 50, 50, 25, 25, 65, 65, 10, 10, 50, 50};
  int ex1 [12] = '{50, 50, 10, 10, 70, 70, 30, 30, 30, 70, 30, 70};
  int ey1 [12] = '{10, 50, 50, 10, 25, 65, 65, 25, 25, 25, 65, 65};

  // Records each line_start rise: endpoints, low cycles before it, and frame_done pulses.
  always @(negedge clk) begin
    prev_start <= lif.line_start;
    low_cnt    <= lif.line_start ? 0 : low_cnt + 1;
    if (lif.line_start && !prev_start) begin
      rise_cnt <= rise_cnt + 1;
      if (edge_idx < 4'd12) begin
        cap_x0[edge_idx] <= lif.line_x0;
        cap_y0[edge_idx] <= lif.line_y0;
        cap_x1[edge_idx] <= lif.line_x1;
        cap_y1[edge_idx] <= lif.line_y1;
        gap_at[edge_idx] <= low_cnt;
      end
    end
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Mode 0: one-cycle done 5 cycles into start; mode 1: done held 4 cycles; mode 2: never answers edge 2.
  initial begin
    int age;
    int hold;
    age  = 0;
    hold = 0;
    lif.line_done = 1'b0;
    forever begin
      @(negedge clk);
      age = lif.line_start ? age + 1 : 0;
      if (hold > 0) begin
        lif.line_done = 1'b1;
        hold--;
      end else if (lif.line_start && age == 5 && !(resp_mode == 2 && edge_idx == 4'd2)) begin
        lif.line_done = 1'b1;
        hold = (resp_mode == 1) ? 3 : 0;
      end else begin
        lif.line_done = 1'b0;
      end
    end
  end

  function automatic logic [63:0] edgeWord(input int x0, input int y0, input int x1, input int y1);
    return {22'd0, 11'(x0), 10'(y0), 11'(x1), 10'(y1)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkEdge(input string tag, input int e);
    checkOutput(tag, edgeWord(int'(cap_x0[e]), int'(cap_y0[e]), int'(cap_x1[e]), int'(cap_y1[e])),
                edgeWord(ex0[e], ey0[e], ex1[e], ey1[e]));
  endtask

  task automatic loadVertices();
    for (int i = 0; i < 8; i++) begin
      vx[i*XW +: XW] = XW'(base_x[i]);
      vy[i*YW +: YW] = YW'(base_y[i]);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic waitEdgeStart(input int idx, input string tag);
    int n;
    n = 0;
    while (!(int'(edge_idx) == idx && lif.line_start) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, (int'(edge_idx) == idx && lif.line_start), 1);
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_seen"}, frame_done, 1);
    checkOutput({tag, "_busy_low_at_done"}, frame_busy, 0);
  endtask

  initial begin
    int rb;
    int db;
    reset       = 1'b1;
    frame_start = 1'b0;
    loadVertices();
    repeat (3) @(negedge clk);
    checkOutput("rst_line_start", lif.line_start, 0);
    checkOutput("rst_frame_busy", frame_busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_edge_idx", edge_idx, 0);
    checkOutput("rst_err_timeout", err_timeout, 0);
    checkOutput("rst_line_x0", lif.line_x0, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] frame A: pulse done");
    rb = rise_cnt;
    db = done_cnt;
    resp_mode = 0;
    applyStimulus();
    checkOutput("a_busy_on_latch", frame_busy, 1);
    checkOutput("a_no_start_in_load", lif.line_start, 0);
    @(negedge clk);
    checkOutput("a_no_start_in_start", lif.line_start, 0);
    checkOutput("a_endpoints_before_start", edgeWord(int'(lif.line_x0), int'(lif.line_y0),
                int'(lif.line_x1), int'(lif.line_y1)), edgeWord(10, 10, 50, 10));
    @(negedge clk);
    checkOutput("a_start_after_2", lif.line_start, 1);
    waitFrameDone("a");
    #1;
    checkOutput("a_rises", rise_cnt - rb, 12);
    checkOutput("a_done_pulses", done_cnt - db, 1);
    checkEdge("a_edge0", 0);
    checkEdge("a_edge3", 3);
    checkEdge("a_edge8", 8);
    checkEdge("a_edge11", 11);
    checkOutput("a_gap_pulse", gap_at[1], 3);

    $display("[TB] frame B: back-to-back, level done");
    rb = rise_cnt;
    resp_mode = 1;
    applyStimulus();
    checkOutput("b_busy_on_latch", frame_busy, 1);
    repeat (2) @(negedge clk);
    checkOutput("b_start_after_2", lif.line_start, 1);
    waitFrameDone("b");
    #1;
    checkOutput("b_rises", rise_cnt - rb, 12);
    checkOutput("b_gap_level", gap_at[1], 6);
    checkOutput("b_gap_level_e11", gap_at[11], 6);
    checkEdge("b_edge5", 5);
    repeat (3) @(negedge clk);
    checkOutput("ab_done_pulses", done_cnt - db, 2);

    $display("[TB] frame C: restart while busy");
    rb = rise_cnt;
    db = done_cnt;
    resp_mode = 0;
    applyStimulus();
    waitEdgeStart(5, "c_reach_edge5");
    vx = '1;
    vy = '1;
    applyStimulus();
    checkOutput("c_ignore_idx", edge_idx, 5);
    waitFrameDone("c");
    #1;
    checkOutput("c_rises", rise_cnt - rb, 12);
    checkEdge("c_edge6", 6);
    checkEdge("c_edge11", 11);
    repeat (3) @(negedge clk);
    checkOutput("c_done_pulses", done_cnt - db, 1);
    loadVertices();

    $display("[TB] frame D: reset mid-wait");
    applyStimulus();
    waitEdgeStart(3, "d_reach_edge3");
    db = done_cnt;
    reset = 1'b1;
    #1;
    checkOutput("d_rst_line_start", lif.line_start, 0);
    checkOutput("d_rst_frame_busy", frame_busy, 0);
    checkOutput("d_rst_edge_idx", edge_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("d_no_done_after_rst", done_cnt - db, 0);
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("d_restart_start", lif.line_start, 1);
    checkOutput("d_restart_idx", edge_idx, 0);
    checkOutput("d_restart_endpoints", edgeWord(int'(lif.line_x0), int'(lif.line_y0),
                int'(lif.line_x1), int'(lif.line_y1)), edgeWord(10, 10, 50, 10));
    waitFrameDone("d");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("d_done_pulses", done_cnt - db, 1);

`ifdef CUBE_SEQ_WATCHDOG_EN
    $display("[TB] frame E: watchdog on edge 2");
    rb = rise_cnt;
    db = done_cnt;
    resp_mode = 2;
    applyStimulus();
    waitEdgeStart(2, "e_reach_edge2");
    repeat (15) @(negedge clk);
    checkOutput("e_err_before_limit", err_timeout, 0);
    checkOutput("e_start_before_limit", lif.line_start, 1);
    @(negedge clk);
    checkOutput("e_err_at_limit", err_timeout, 1);
    checkOutput("e_start_dropped", lif.line_start, 0);
    waitFrameDone("e");
    #1;
    checkOutput("e_rises", rise_cnt - rb, 12);
    checkEdge("e_edge3", 3);
    checkEdge("e_edge11", 11);
    repeat (3) @(negedge clk);
    checkOutput("e_done_pulses", done_cnt - db, 1);
    checkOutput("e_err_sticky", err_timeout, 1);
`else
    checkOutput("err_tied_low", err_timeout, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
